// File: rtl/playbus_pkg.sv
// Shared types for the PlayBus control-strobe sequencer.
package playbus_pkg;

    // Width of the setup/hold cycle counter; covers SETUP/HOLD values 1..15.
    localparam int CNT_W = 4;

    // Transfer types: which bus driver is enabled and which strobe fires.
    typedef enum logic [1:0] {
        OP_SW2RAM  = 2'd0,
        OP_RAM2LED = 2'd1,
        OP_ROM2LED = 2'd2,
        OP_SW2LED  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/playbus_strobe_decode.sv
// Combinational map from (op, state) to the five PlayBus control lines.
// The driver is on for SETUP/STROBE/HOLD and the strobe only in STROBE, so
// the strobe is always nested strictly inside the driver window.
module playbus_strobe_decode
    import playbus_pkg::*;
(
    input  logic [1:0] op,
    input  logic [2:0] state,
    output logic       ramo,
    output logic       romo,
    output logic       swben,
    output logic       ramw,
    output logic       ledltch
);

    logic drive;
    logic stb;

    assign drive = (state_t'(state) == SETUP) || (state_t'(state) == STROBE) ||
                   (state_t'(state) == HOLD);
    assign stb   = (state_t'(state) == STROBE);

    // Route the driver/strobe window onto exactly one driver and one strobe.
    always_comb begin
        ramo    = 1'b0;
        romo    = 1'b0;
        swben   = 1'b0;
        ramw    = 1'b0;
        ledltch = 1'b0;
        case (op_t'(op))
            OP_SW2RAM: begin
                swben = drive;
                ramw  = stb;
            end
            OP_RAM2LED: begin
                ramo    = drive;
                ledltch = stb;
            end
            OP_ROM2LED: begin
                romo    = drive;
                ledltch = stb;
            end
            OP_SW2LED: begin
                swben   = drive;
                ledltch = stb;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/playbus_sequencer.sv
// PlayBus control-strobe sequencer: runs SETUP / STROBE / HOLD / DONE for
// each accepted start and drives RAMO, ROMO, SWBEN, RAMW and LEDLTCH.
// All outputs are flops decoded from the current state, so they trail the
// FSM by one cycle and have no combinational path from any input.
// Optional build macro PLAYBUS_SEQ_AUTOINC_EN: addr becomes an internal
// counter that advances after each completed transfer; addr_in is ignored.
module playbus_sequencer
    import playbus_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic              n_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              RAMO,
    output logic              ROMO,
    output logic              SWBEN,
    output logic              RAMW,
    output logic              LEDLTCH
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    op_t              op_r;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             d_ramo;
    logic             d_romo;
    logic             d_swben;
    logic             d_ramw;
    logic             d_ledltch;

    // busy still covers the visible DONE cycle while the FSM already sits in
    // IDLE, so gating on it keeps a start in that cycle from being taken.
    assign accept = (state == IDLE) && start && !busy;

    playbus_strobe_decode u_decode (
        .op      (op_r),
        .state   (state),
        .ramo    (d_ramo),
        .romo    (d_romo),
        .swben   (d_swben),
        .ramw    (d_ramw),
        .ledltch (d_ledltch)
    );

    // Sequencer FSM, cycle counter and registered control outputs.
    always_ff @(posedge n_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= OP_SW2RAM;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            RAMO    <= 1'b0;
            ROMO    <= 1'b0;
            SWBEN   <= 1'b0;
            RAMW    <= 1'b0;
            LEDLTCH <= 1'b0;
        end else begin
            busy    <= (state == IDLE) ? accept : 1'b1;
            done    <= (state == DONE);
            RAMO    <= d_ramo;
            ROMO    <= d_romo;
            SWBEN   <= d_swben;
            RAMW    <= d_ramw;
            LEDLTCH <= d_ledltch;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= op_t'(op);
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) state <= STROBE;
                    else           cnt   <= cnt - 1'b1;
                end
                STROBE: begin
                    cnt   <= HOLD_LD;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PLAYBUS_SEQ_AUTOINC_EN
    // addr_in is not used in this build.
    logic unused_addr_in;
    assign unused_addr_in = ^addr_in;

    // Sweep address: advances once the done pulse has been shown, so it is
    // stable over the whole driver window and the done cycle.
    always_ff @(posedge n_clk or posedge reset) begin
        if (reset)     addr <= '0;
        else if (done) addr <= addr + 1'b1;
    end
`else
    // Address captured with the accepted start and held until the next one.
    always_ff @(posedge n_clk or posedge reset) begin
        if (reset)       addr <= '0;
        else if (accept) addr <= addr_in;
    end
`endif

endmodule

// File: tb/tb_playbus_sequencer.sv
// Scoreboard bench for playbus_sequencer: stimulus pushes the expected
// transfer signature, a negedge monitor measures each transfer and pops on done.
module tb_playbus_sequencer;

    typedef struct {
        logic [2:0] drv;   // {RAMO,ROMO,SWBEN} seen during the transfer
        logic [1:0] stb;   // {RAMW,LEDLTCH} seen during the transfer
        int         ncyc;  // driver-high cycles
        int         spos;  // driver cycle (1-based) carrying the strobe
        logic [3:0] addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_start, b_start;
    logic [1:0] a_op, b_op;
    logic [3:0] a_addr_in, b_addr_in;
    logic [3:0] a_addr, b_addr;
    logic       a_busy, a_done, a_RAMO, a_ROMO, a_SWBEN, a_RAMW, a_LEDLTCH;
    logic       b_busy, b_done, b_RAMO, b_ROMO, b_SWBEN, b_RAMW, b_LEDLTCH;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] a_ctr = 4'd0;
    logic [3:0] b_ctr = 4'd0;

    playbus_sequencer dut_a (
        .n_clk(clk), .reset(reset), .start(a_start), .op(a_op), .addr_in(a_addr_in),
        .addr(a_addr), .busy(a_busy), .done(a_done), .RAMO(a_RAMO), .ROMO(a_ROMO),
        .SWBEN(a_SWBEN), .RAMW(a_RAMW), .LEDLTCH(a_LEDLTCH)
    );

    playbus_sequencer #(.ADDR_W(4), .SETUP_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
        .n_clk(clk), .reset(reset), .start(b_start), .op(b_op), .addr_in(b_addr_in),
        .addr(b_addr), .busy(b_busy), .done(b_done), .RAMO(b_RAMO), .ROMO(b_ROMO),
        .SWBEN(b_SWBEN), .RAMW(b_RAMW), .LEDLTCH(b_LEDLTCH)
    );

    logic [1:0][2:0] drv;
    logic [1:0][1:0] stb;
    logic [1:0]      dn;
    logic [1:0][3:0] ad;
    assign drv[0] = {a_RAMO, a_ROMO, a_SWBEN};
    assign drv[1] = {b_RAMO, b_ROMO, b_SWBEN};
    assign stb[0] = {a_RAMW, a_LEDLTCH};
    assign stb[1] = {b_RAMW, b_LEDLTCH};
    assign dn     = {b_done, a_done};
    assign ad[0]  = a_addr;
    assign ad[1]  = b_addr;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] op, input int ncyc, input int spos,
                                input logic [3:0] addr);
        exp_t e;
        case (op)
            2'd0:    begin e.drv = 3'b001; e.stb = 2'b10; end
            2'd1:    begin e.drv = 3'b100; e.stb = 2'b01; end
            2'd2:    begin e.drv = 3'b010; e.stb = 2'b01; end
            default: begin e.drv = 3'b001; e.stb = 2'b01; end
        endcase
        e.ncyc = ncyc;
        e.spos = spos;
        e.addr = addr;
        return e;
    endfunction

    // Expected address for the next default-parameter transfer.
    function automatic logic [3:0] next_a_addr(input logic [3:0] ain);
`ifdef PLAYBUS_SEQ_AUTOINC_EN
        logic [3:0] r;
        r = a_ctr;
        a_ctr = a_ctr + 4'd1;
        return r;
`else
        return ain;
`endif
    endfunction

    // ---------------- monitor ----------------
    int         dcnt[2], spos[2], ndone[2];
    logic [2:0] dacc[2], pdrv[2];
    logic [1:0] sacc[2];
    logic [3:0] a0[2];

    task automatic mon_clear(input int d);
        dcnt[d] = 0; spos[d] = 0; dacc[d] = '0; sacc[d] = '0; a0[d] = '0;
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (reset) begin
            mon_clear(d);
            pdrv[d] = '0;
            return;
        end
        check($sformatf("drv_onehot%0d", d), $countones(drv[d]) <= 1, 1);
        check($sformatf("ramw_without_swben%0d", d), stb[d][1] && !drv[d][0], 0);
        check($sformatf("ledltch_without_drv%0d", d), stb[d][0] && (drv[d] == 3'b000), 0);
        check($sformatf("driver_handover_gap%0d", d),
              (pdrv[d] != 0) && (drv[d] != 0) && (pdrv[d] != drv[d]), 0);
        if (drv[d] != 0) begin
            if (dcnt[d] == 0) a0[d] = ad[d];
            else check($sformatf("addr_stable%0d", d), ad[d], a0[d]);
            dcnt[d]++;
            dacc[d] |= drv[d];
            if (stb[d] != 0) begin
                if (spos[d] != 0) check($sformatf("strobe_single%0d", d), dcnt[d], spos[d]);
                spos[d] = dcnt[d];
                sacc[d] |= stb[d];
            end
        end
        if (dn[d]) begin
            ndone[d]++;
            check($sformatf("drv_off_at_done%0d", d), drv[d], 0);
            check($sformatf("done_after_drv%0d", d), pdrv[d] != 0, 1);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_done%0d", d), 1, 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("driver%0d", d), dacc[d], e.drv);
                check($sformatf("strobe%0d", d), sacc[d], e.stb);
                check($sformatf("drv_cycles%0d", d), dcnt[d], e.ncyc);
                check($sformatf("strobe_pos%0d", d), spos[d], e.spos);
                check($sformatf("addr%0d", d), a0[d], e.addr);
                check($sformatf("addr_at_done%0d", d), ad[d], e.addr);
            end
            mon_clear(d);
        end
        pdrv[d] = drv[d];
    endtask

    initial begin
        ndone[0] = 0; ndone[1] = 0;
        mon_clear(0); mon_clear(1);
        pdrv[0] = '0; pdrv[1] = '0;
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_q0();
        for (int i = 0; i < 100 && q0.size() != 0; i++) @(negedge clk);
        check("q0_drained", q0.size(), 0);
    endtask

    task automatic run_a(input logic [1:0] op, input logic [3:0] ain);
        @(negedge clk);
        a_start = 1'b1; a_op = op; a_addr_in = ain;
        q0.push_back(mk(op, 3, 2, next_a_addr(ain)));
        @(negedge clk);
        a_start = 1'b0; a_op = ~op; a_addr_in = ~ain;   // post-acceptance changes
        wait_q0();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_start = 0; a_op = 0; a_addr_in = 0;
        b_start = 0; b_op = 0; b_addr_in = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_drv", {a_RAMO, a_ROMO, a_SWBEN}, 0);
        check("rst_stb", {a_RAMW, a_LEDLTCH}, 0);
        check("rst_addr", a_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of the SW2RAM strobe cycle.
        a_start = 1'b1; a_op = 2'd0; a_addr_in = 4'h9;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 20 && !a_RAMW; i++) @(negedge clk);
        check("reach_strobe", a_RAMW, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_swben", a_SWBEN, 0);
        check("async_rst_ramw", a_RAMW, 0);
        check("async_rst_busy", a_busy, 0);
        q0.delete();
        a_ctr = 4'd0; b_ctr = 4'd0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", a_busy, 0);
        check("post_rst_addr", a_addr, 0);
        check("post_rst_swben", a_SWBEN, 0);

        // SW2RAM, addr A, with explicit cycle-by-cycle latency checks.
        a_start = 1'b1; a_op = 2'd0; a_addr_in = 4'hA;
        q0.push_back(mk(2'd0, 3, 2, next_a_addr(4'hA)));
        @(negedge clk);                       // start accepted at this edge
        a_start = 1'b0; a_op = 2'd3; a_addr_in = 4'h5;
        check("lat0_busy", a_busy, 1);
        check("lat0_swben", a_SWBEN, 0);
        @(negedge clk);
        check("lat1_swben", a_SWBEN, 1);
        check("lat1_ramw", a_RAMW, 0);
        @(negedge clk);
        check("lat2_ramw", a_RAMW, 1);
        @(negedge clk);
        check("lat3_swben", a_SWBEN, 1);
        check("lat3_ramw", a_RAMW, 0);
        @(negedge clk);
        check("lat4_done", a_done, 1);
        check("lat4_busy", a_busy, 1);
        @(negedge clk);
        check("lat5_done", a_done, 0);
        check("lat5_busy", a_busy, 0);
        wait_q0();

        // ROM2LED on the SETUP=3 / HOLD=2 instance.
        @(negedge clk);
        b_start = 1'b1; b_op = 2'd2; b_addr_in = 4'h5;
`ifdef PLAYBUS_SEQ_AUTOINC_EN
        q1.push_back(mk(2'd2, 6, 4, b_ctr));
        b_ctr = b_ctr + 4'd1;
`else
        q1.push_back(mk(2'd2, 6, 4, 4'h5));
`endif
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 100 && q1.size() != 0; i++) @(negedge clk);
        check("q1_drained", q1.size(), 0);

        // Back-to-back: RAM2LED then SW2LED with start held high.
        @(negedge clk);
        a_start = 1'b1; a_op = 2'd1; a_addr_in = 4'h2;
        q0.push_back(mk(2'd1, 3, 2, next_a_addr(4'h2)));
        @(negedge clk);
        a_op = 2'd3; a_addr_in = 4'hC;
        q0.push_back(mk(2'd3, 3, 2, next_a_addr(4'hC)));
        for (int i = 0; i < 20 && !a_done; i++) @(negedge clk);
        check("b2b_first_done", a_done, 1);
        @(negedge clk);
        check("b2b_gap_busy", a_busy, 0);
        @(negedge clk);
        check("b2b_second_busy", a_busy, 1);
        a_start = 1'b0;
        wait_q0();
        @(negedge clk);

        // start re-issued with op=ROM2LED while RAM2LED is busy: ignored.
        a_start = 1'b1; a_op = 2'd1; a_addr_in = 4'h3;
        q0.push_back(mk(2'd1, 3, 2, next_a_addr(4'h3)));
        @(negedge clk);
        a_op = 2'd2; a_addr_in = 4'h7;
        repeat (3) @(negedge clk);
        a_start = 1'b0;
        wait_q0();
        repeat (8) @(negedge clk);
        check("ignore_single_done", ndone[0], 4);

        // 17 ROM2LED transfers from a fresh reset (address sweep in autoinc).
        reset = 1'b1;
        a_ctr = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) run_a(2'd2, 4'(15 - i));

        check("total_done_a", ndone[0], 21);
        check("total_done_b", ndone[1], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
